// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock, round keys are read
// combinationally from an external key store addressed by rk_addr.
module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_addr,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 by repeated squaring; 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] b;
    r = 8'h01;
    b = a;
    for (int i = 0; i < 7; i++) begin
      b = gmul(b, b);
      r = gmul(r, b);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  // Byte k sits at bits [127-8k -: 8]; row = k%4, column = k/4.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic mix);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    int           row, col, src;
    for (int k = 0; k < 16; k++) begin
      row  = k % 4;
      col  = k / 4;
      src  = 4 * ((col + 4 - row) % 4) + row;
      b[k] = inv_sbox(s[127-8*src -: 8]) ^ rk[127-8*k -: 8];
    end
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a0 = b[4*c];
        a1 = b[4*c+1];
        a2 = b[4*c+2];
        a3 = b[4*c+3];
        t[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        t[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        t[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        t[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
    end else begin
      t = b;
    end
    r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = t[k];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = in_data ^ rk_data;
          rnd_d   = NR_L - 4'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        // The last round (rnd == 0) skips InvMixColumns.
        st_d = inv_round(st_q, rk_data, rnd_q != 4'd0);
        if (rnd_q == 4'd0) state_d = DONE;
        else               rnd_d   = rnd_q - 4'd1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_data  = st_q;
    case (state_q)
      IDLE:    rk_addr = NR_L;
      RUN:     rk_addr = rnd_q;
      default: rk_addr = 4'd0;
    endcase
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

Iterative AES inverse cipher: accepts one 128-bit ciphertext block over a valid/ready handshake, runs one inverse round per clock, and returns the plaintext over a second valid/ready handshake. Each round is built from the team's combinational inverse ShiftRows, inverse SubBytes and inverse MixColumns blocks. Round keys come from an external round-key store that is read combinationally by index. The block is the decryption counterpart of the forward round datapath and sits between the bus-side block buffer and the round-key store.

## Interface
- NR, 10, number of rounds; legal values 10, 12, 14 (AES-128/192/256); any other value is a synthesis-time error.
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  ciphertext on in_data is valid
- in_ready  output  1  block can accept a ciphertext
- in_data  input  128  ciphertext, bits [0:127], byte k = bits [8k:8k+7], column-major (bytes 0..3 = column 0)
- rk_addr  output  4  round-key index requested this cycle, 0..NR
- rk_data  input  128  round key for rk_addr, same-cycle combinational read, same byte order as in_data
- out_valid  output  1  plaintext on out_data is valid
- out_ready  input  1  consumer accepts plaintext
- out_data  output  128  plaintext, same byte order
- busy  output  1  high from acceptance until the output handshake completes

## Operation
- FSM states: IDLE, RUN, DONE. Round counter rnd is 4 bits wide.
- IDLE
  - in_ready=1, rk_addr=NR.
  - When in_valid: st <= in_data ^ rk_data, rnd <= NR-1, go to RUN.
- RUN
  - rk_addr=rnd.
  - When rnd != 0: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk_data), rnd <= rnd-1.
  - When rnd == 0: st <= InvSubBytes(InvShiftRows(st)) ^ rk_data, go to DONE.
- DONE
  - out_valid=1, out_data=st, held stable while out_ready=0.
  - When out_ready: go to IDLE.
  - A new block cannot be accepted in the same cycle as the output handshake (in_ready=0 in DONE).
- rk_addr in DONE = 0; its value there is don't-care to the key store.
- busy = (FSM != IDLE).
- InvShiftRows: row r of the state is rotated right by r byte positions. Example: out byte 1 = in byte 13; out byte 5 = in byte 1.
- in_data and in_valid are ignored outside IDLE; no input buffering.
- Reset, including mid-operation: FSM -> IDLE, rnd=0, st=0, in-flight block discarded, no out_valid pulse.

## Timing
- Reset values: in_ready=0 while rst is high, 1 in the first cycle after rst deasserts. out_valid=0, out_data=0, busy=0, rk_addr=NR.
- Acceptance at cycle T (in_valid & in_ready). RUN occupies cycles T+1..T+NR. out_valid rises at T+NR+1; latency is 11/13/15 cycles for NR 10/12/14.
- rk_addr sequence from T: NR, NR-1, ..., 0, one value per cycle. rk_data must settle within the same cycle.
- Throughput with out_ready held high: one block per NR+2 cycles (DONE occupies 1 cycle, IDLE 1 cycle).
- out_valid deasserts the cycle after the handshake. It never drops without a handshake, except on rst.
- The critical path is one full inverse round plus the key XOR; no internal pipelining.

## Test plan
- FIPS-197 App. B, NR=10
  - Stimulus: in_data=3925841d02dc09fbdc118597196a0b32, key store expanded from 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: rk_addr at T = 10 (rk_data d014f9a8c9ee2589e13f0cc8b6630ca6); out_data=3243f6a8885a308d313198a2e0370734 with out_valid at exactly T+11.
- FIPS-197 C.1 (NR=10), C.2 (NR=12), C.3 (NR=14)
  - Stimulus: keys 000102..0f / ..17 / ..1f; ciphertexts 69c4e0d86a7b0430d8cdb78070b4c55a, dda97ca4864cdfe06eaf70a0ec0d7191, 8ea2b7ca516745bfeafc49904b496089.
  - Required: out_data=00112233445566778899aabbccddeeff, at latency 11/13/15.
- Backpressure
  - Stimulus: out_ready held 0 for 20 cycles after out_valid, with in_valid held high.
  - Required: out_data stable, in_ready=0 throughout; handshake on the cycle out_ready=1; in_ready=1 on the next cycle; the next block is accepted there.
- Reset mid-run
  - Stimulus: assert rst for 1 cycle at T+5.
  - Required: next cycle busy=0, in_ready=1, out_valid=0, out_data=0; no stale output ever appears; a following App. B block decrypts correctly.
- Back-to-back stream
  - Stimulus: 100 random key/plaintext pairs encrypted by the reference model, in_valid and out_ready randomly toggled.
  - Required: every out_data matches its plaintext in order, rk_addr sequence is NR..0 per block, and no block is dropped or duplicated.
